// File: rtl/spi_config_receiver.sv
// SPI mode-0 configuration slave: synchronises the raw link into clk and turns
// each well-formed {addr, data} frame into a one-cycle cfgValid strobe.
//
// state | meaning
// IDLE  | waiting for a chip-select falling edge; spiClk edges ignored
// SHIFT | frame in progress; shifting on spiClk rises until chip select rises
module spi_config_receiver #(
   parameter int ADDR_WIDTH  = 4,
   parameter int DATA_WIDTH  = 12,
   parameter int SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  spiClk,
   input  logic                  mosi,
   input  logic                  cs,
   output logic [ADDR_WIDTH-1:0] cfgAddr,
   output logic [DATA_WIDTH-1:0] cfgData,
   output logic                  cfgValid,
   output logic                  frameError,
   output logic                  busy
);

   localparam int FRAME_BITS = ADDR_WIDTH + DATA_WIDTH;
   localparam int CNT_W      = $clog2(FRAME_BITS + 2);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
   localparam logic [CNT_W-1:0] CNT_OVER = CNT_W'(FRAME_BITS + 1);

   typedef enum logic {IDLE, SHIFT} stateT;

   logic [SYNC_STAGES-1:0] spiClkSync, mosiSync, csSync;
   logic                   spiClkPrev, csPrev, mosiAligned;
   logic                   spiRise, csRise, csFall;
   logic [SYNC_STAGES:0]   validPipe;
   logic                   armed;

   stateT                  state, stateNext;
   logic [FRAME_BITS-1:0]  shiftReg, shiftNext;
   logic [CNT_W-1:0]       count, countNext;
   logic [ADDR_WIDTH-1:0]  addrNext;
   logic [DATA_WIDTH-1:0]  dataNext;
   logic                   validNext, errorNext;

   // validPipe marks when csPrev holds a genuinely sampled level rather than the
   // reset value, so a frame already running at reset release is never entered.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         spiClkSync  <= '0;
         mosiSync    <= '0;
         csSync      <= '1;
         spiClkPrev  <= 1'b0;
         csPrev      <= 1'b1;
         mosiAligned <= 1'b0;
         spiRise     <= 1'b0;
         csRise      <= 1'b0;
         csFall      <= 1'b0;
         validPipe   <= '0;
         armed       <= 1'b0;
      end else begin
         spiClkSync  <= {spiClkSync[SYNC_STAGES-2:0], spiClk};
         mosiSync    <= {mosiSync[SYNC_STAGES-2:0], mosi};
         csSync      <= {csSync[SYNC_STAGES-2:0], cs};
         spiClkPrev  <= spiClkSync[SYNC_STAGES-1];
         csPrev      <= csSync[SYNC_STAGES-1];
         mosiAligned <= mosiSync[SYNC_STAGES-1];
         spiRise     <= spiClkSync[SYNC_STAGES-1] & ~spiClkPrev;
         csRise      <= csSync[SYNC_STAGES-1] & ~csPrev;
         csFall      <= ~csSync[SYNC_STAGES-1] & csPrev & (armed | validPipe[SYNC_STAGES]);
         validPipe   <= {validPipe[SYNC_STAGES-1:0], 1'b1};
         armed       <= armed | (validPipe[SYNC_STAGES] & csPrev);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         shiftReg   <= '0;
         count      <= '0;
         cfgAddr    <= '0;
         cfgData    <= '0;
         cfgValid   <= 1'b0;
         frameError <= 1'b0;
      end else begin
         state      <= stateNext;
         shiftReg   <= shiftNext;
         count      <= countNext;
         cfgAddr    <= addrNext;
         cfgData    <= dataNext;
         cfgValid   <= validNext;
         frameError <= errorNext;
      end
   end

   // A spiClk rise landing in the same cycle as the cs rise is shifted first,
   // so the frame is judged on the updated count and contents.
   always_comb begin
      stateNext = state;
      shiftNext = shiftReg;
      countNext = count;
      addrNext  = cfgAddr;
      dataNext  = cfgData;
      validNext = 1'b0;
      errorNext = 1'b0;
      case (state)
         IDLE: begin
            if (csFall) begin
               stateNext = SHIFT;
               shiftNext = '0;
               countNext = '0;
            end
         end
         SHIFT: begin
            if (spiRise) begin
               shiftNext = {shiftReg[FRAME_BITS-2:0], mosiAligned};
               if (count != CNT_OVER) countNext = count + CNT_W'(1);
            end
            if (csRise) begin
               stateNext = IDLE;
               if (countNext == CNT_FULL) begin
                  addrNext  = shiftNext[FRAME_BITS-1 -: ADDR_WIDTH];
                  dataNext  = shiftNext[DATA_WIDTH-1:0];
                  validNext = 1'b1;
               end else begin
                  errorNext = 1'b1;
               end
            end
         end
         default: stateNext = IDLE;
      endcase
   end

   assign busy = (state == SHIFT);

endmodule

// File: tb/tb_spi_config_receiver.sv
// Directed bench for spi_config_receiver: frames driven bit by bit at clk/8,
// outputs sampled on the falling clk edge by a small pulse logger.
module tb_spi_config_receiver;

   logic        clk = 1'b0;
   logic        rstN = 1'b0;
   logic        spiClk = 1'b0;
   logic        mosi = 1'b0;
   logic        cs = 1'b1;
   logic [3:0]  cfgAddr;
   logic [11:0] cfgData;
   logic        cfgValid, frameError, busy;

   int passed = 0;
   int total = 0;

   spi_config_receiver #(.ADDR_WIDTH(4), .DATA_WIDTH(12), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(rstN), .spiClk(spiClk), .mosi(mosi), .cs(cs),
      .cfgAddr(cfgAddr), .cfgData(cfgData), .cfgValid(cfgValid),
      .frameError(frameError), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          validCnt = 0, errCnt = 0, bothCnt = 0, busyHighCnt = 0;
   logic        busyPrev = 1'b0;
   logic [3:0]  logAddr[16];
   logic [11:0] logData[16];
   int          logCyc[16];
   logic        logBusy[16], logBusyPrev[16];

   always @(negedge clk) begin
      if (cfgValid && frameError) bothCnt++;
      if (busy) busyHighCnt++;
      if (cfgValid) begin
         logAddr[validCnt[3:0]]     = cfgAddr;
         logData[validCnt[3:0]]     = cfgData;
         logCyc[validCnt[3:0]]      = cyc;
         logBusy[validCnt[3:0]]     = busy;
         logBusyPrev[validCnt[3:0]] = busyPrev;
         validCnt++;
      end
      if (frameError) errCnt++;
      busyPrev = busy;
   end

   task automatic waitClk(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic shiftBits(input logic [31:0] bits, input int n, input bit coincident);
      for (int i = n - 1; i >= 0; i--) begin
         mosi = bits[i];
         spiClk = 1'b0;
         waitClk(4);
         spiClk = 1'b1;
         if (coincident && i == 0) cs = 1'b1;
         else waitClk(4);
      end
   endtask

   task automatic sendFrame(input logic [31:0] bits, input int n, input bit coincident);
      cs = 1'b0;
      waitClk(4);
      shiftBits(bits, n, coincident);
      if (!coincident) begin
         spiClk = 1'b0;
         waitClk(4);
         cs = 1'b1;
      end
   endtask

   task automatic test_reset();
      waitClk(3);
      total++; if (cfgAddr !== 4'h0) $display("FAIL reset_addr: got %h expected 0", cfgAddr); else passed++;
      total++; if (cfgData !== 12'h0) $display("FAIL reset_data: got %h expected 0", cfgData); else passed++;
      total++; if (cfgValid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", cfgValid); else passed++;
      total++; if (frameError !== 1'b0) $display("FAIL reset_error: got %b expected 0", frameError); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
      rstN = 1'b1;
      waitClk(6);
   endtask

   task automatic test_single_frame();
      int v0, e0, rc;
      v0 = validCnt; e0 = errCnt;
      sendFrame(32'h3A5C, 16, 1'b0);
      rc = cyc;
      waitClk(14);
      total++; if (validCnt - v0 != 1) $display("FAIL t1_valid_count: got %0d expected 1", validCnt - v0); else passed++;
      total++; if (errCnt - e0 != 0) $display("FAIL t1_error_count: got %0d expected 0", errCnt - e0); else passed++;
      total++; if (logAddr[v0[3:0]] !== 4'h3) $display("FAIL t1_addr: got %h expected 3", logAddr[v0[3:0]]); else passed++;
      total++; if (logData[v0[3:0]] !== 12'hA5C) $display("FAIL t1_data: got %h expected a5c", logData[v0[3:0]]); else passed++;
      total++; if (logCyc[v0[3:0]] != rc + 4) $display("FAIL t1_latency: got %0d expected %0d", logCyc[v0[3:0]] - rc, 4); else passed++;
   endtask

   task automatic test_bad_length();
      int v0, e0;
      v0 = validCnt; e0 = errCnt;
      sendFrame(32'h1234, 15, 1'b0);
      waitClk(14);
      sendFrame(32'h1ABCD, 17, 1'b0);
      waitClk(14);
      total++; if (errCnt - e0 != 2) $display("FAIL t2_error_count: got %0d expected 2", errCnt - e0); else passed++;
      total++; if (validCnt - v0 != 0) $display("FAIL t2_valid_count: got %0d expected 0", validCnt - v0); else passed++;
      total++; if (cfgAddr !== 4'h3) $display("FAIL t2_addr_hold: got %h expected 3", cfgAddr); else passed++;
      total++; if (cfgData !== 12'hA5C) $display("FAIL t2_data_hold: got %h expected a5c", cfgData); else passed++;
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = validCnt;
      sendFrame(32'h1001, 16, 1'b0);
      waitClk(4);
      sendFrame(32'hFFFF, 16, 1'b0);
      waitClk(14);
      total++; if (validCnt - v0 != 2) $display("FAIL t3_valid_count: got %0d expected 2", validCnt - v0); else passed++;
      total++; if (logAddr[v0[3:0]] !== 4'h1) $display("FAIL t3_addr0: got %h expected 1", logAddr[v0[3:0]]); else passed++;
      total++; if (logData[v0[3:0]] !== 12'h001) $display("FAIL t3_data0: got %h expected 001", logData[v0[3:0]]); else passed++;
      v0 = v0 + 1;
      total++; if (logAddr[v0[3:0]] !== 4'hF) $display("FAIL t3_addr1: got %h expected f", logAddr[v0[3:0]]); else passed++;
      total++; if (logData[v0[3:0]] !== 12'hFFF) $display("FAIL t3_data1: got %h expected fff", logData[v0[3:0]]); else passed++;
   endtask

   task automatic test_reset_mid_frame();
      int v0, e0;
      cs = 1'b0;
      waitClk(4);
      shiftBits(32'hA5, 8, 1'b0);
      rstN = 1'b0;
      waitClk(2);
      rstN = 1'b1;
      waitClk(3);
      total++; if (cfgAddr !== 4'h0) $display("FAIL t4_addr_cleared: got %h expected 0", cfgAddr); else passed++;
      total++; if (cfgData !== 12'h0) $display("FAIL t4_data_cleared: got %h expected 0", cfgData); else passed++;
      total++; if (busy !== 1'b0) $display("FAIL t4_busy_cleared: got %b expected 0", busy); else passed++;
      v0 = validCnt; e0 = errCnt;
      spiClk = 1'b0;
      cs = 1'b1;
      waitClk(14);
      total++; if ((validCnt - v0) + (errCnt - e0) != 0) $display("FAIL t4_no_pulse: got %0d pulses expected 0", (validCnt - v0) + (errCnt - e0)); else passed++;
      sendFrame(32'h7123, 16, 1'b0);
      waitClk(14);
      total++; if (validCnt - v0 != 1) $display("FAIL t4_valid_count: got %0d expected 1", validCnt - v0); else passed++;
      total++; if (cfgAddr !== 4'h7) $display("FAIL t4_addr: got %h expected 7", cfgAddr); else passed++;
      total++; if (cfgData !== 12'h123) $display("FAIL t4_data: got %h expected 123", cfgData); else passed++;
   endtask

   task automatic test_clk_without_cs();
      int v0, e0, b0;
      v0 = validCnt; e0 = errCnt; b0 = busyHighCnt;
      cs = 1'b1;
      for (int i = 0; i < 20; i++) begin
         mosi = i[0];
         spiClk = ~spiClk;
         waitClk(4);
      end
      waitClk(8);
      total++; if (busyHighCnt - b0 != 0) $display("FAIL t5_busy: got %0d busy cycles expected 0", busyHighCnt - b0); else passed++;
      total++; if ((validCnt - v0) + (errCnt - e0) != 0) $display("FAIL t5_no_pulse: got %0d pulses expected 0", (validCnt - v0) + (errCnt - e0)); else passed++;
   endtask

   task automatic test_coincident_edge();
      int v0;
      v0 = validCnt;
      spiClk = 1'b0;
      waitClk(4);
      sendFrame(32'h53C9, 16, 1'b1);
      waitClk(4);
      spiClk = 1'b0;
      waitClk(10);
      total++; if (validCnt - v0 != 1) $display("FAIL t6_valid_count: got %0d expected 1", validCnt - v0); else passed++;
      total++; if (logAddr[v0[3:0]] !== 4'h5) $display("FAIL t6_addr: got %h expected 5", logAddr[v0[3:0]]); else passed++;
      total++; if (logData[v0[3:0]] !== 12'h3C9) $display("FAIL t6_data: got %h expected 3c9", logData[v0[3:0]]); else passed++;
      total++; if (logBusy[v0[3:0]] !== 1'b0) $display("FAIL t6_busy_at_pulse: got %b expected 0", logBusy[v0[3:0]]); else passed++;
      total++; if (logBusyPrev[v0[3:0]] !== 1'b1) $display("FAIL t6_busy_before_pulse: got %b expected 1", logBusyPrev[v0[3:0]]); else passed++;
      total++; if (bothCnt != 0) $display("FAIL valid_error_overlap: got %0d cycles expected 0", bothCnt); else passed++;
   endtask

   initial begin
      test_reset();
      test_single_frame();
      test_bad_length();
      test_back_to_back();
      test_reset_mid_frame();
      test_clk_without_cs();
      test_coincident_edge();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
